// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, default frame parameters and
// a counter sizing helper. Shared by uart_rx and the future uart_tx.
package uart_pkg;

  localparam int unsigned UART_NUM_TICKS = 16;  // oversample ratio
  localparam int unsigned UART_DATA_BITS = 8;   // data bits per frame
  localparam int unsigned UART_SB_TICKS  = 16;  // ticks spent in stop state

  typedef enum logic [1:0] {
    UART_IDLE  = 2'b00,
    UART_START = 2'b01,
    UART_DATA  = 2'b10,
    UART_STOP  = 2'b11
  } uart_state_e;

  // Width of a tick counter that must reach max(a, b) - 1.
  function automatic int unsigned uart_cnt_width(input int unsigned a,
                                                 input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m <= 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/rx_sync.sv
// Two-flop synchronizer for an asynchronous serial line.
// Outputs preset to 1 on reset so an idle (high) line is seen immediately.
// Ports: clk_i clock, rst_ni async active-low reset, d_i async input,
//        q_o synchronized output (lags d_i by 2 clocks).
module rx_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver. Reconstructs LSB-first frames from the 16x oversample tick
// and the asynchronous RX line; samples each bit mid-bit.
// Ports: CLK clock, reset async active-low, TICK oversample strobe,
//        RX serial line (idles high), DOUT last good byte,
//        RX_DONE one-cycle pulse on DOUT update,
//        FRAME_ERR one-cycle pulse when the stop bit is sampled low.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS = UART_DATA_BITS,
  parameter int unsigned SB_TICKS  = UART_SB_TICKS,
  parameter int unsigned NUM_TICKS = UART_NUM_TICKS
) (
  input  logic                 CLK,
  input  logic                 reset,
  input  logic                 TICK,
  input  logic                 RX,
  output logic [DATA_BITS-1:0] DOUT,
  output logic                 RX_DONE,
  output logic                 FRAME_ERR
);

  localparam int unsigned SW = uart_cnt_width(NUM_TICKS, SB_TICKS);
  localparam int unsigned NW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [SW-1:0] S_MID  = SW'(NUM_TICKS / 2 - 1);
  localparam logic [SW-1:0] S_LAST = SW'(NUM_TICKS - 1);
  localparam logic [SW-1:0] S_STOP = SW'(SB_TICKS - 1);
  localparam logic [NW-1:0] N_LAST = NW'(DATA_BITS - 1);

  logic rx_s;

  uart_state_e          state_q, state_d;
  logic [SW-1:0]        s_cnt_q, s_cnt_d;
  logic [NW-1:0]        n_cnt_q, n_cnt_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [DATA_BITS-1:0] dout_q, dout_d;
  logic                 done_q, done_d;
  logic                 ferr_q, ferr_d;

  // Line synchronizer; all decisions use rx_s.
  rx_sync u_rx_sync (
    .clk_i  (CLK),
    .rst_ni (reset),
    .d_i    (RX),
    .q_o    (rx_s)
  );

  // State and datapath registers.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q <= UART_IDLE;
      s_cnt_q <= '0;
      n_cnt_q <= '0;
      shreg_q <= '0;
      dout_q  <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s_cnt_q <= s_cnt_d;
      n_cnt_q <= n_cnt_d;
      shreg_q <= shreg_d;
      dout_q  <= dout_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
    end
  end

  // Next-state logic. Only IDLE->START is allowed off a non-tick cycle.
  always_comb begin
    state_d = state_q;
    s_cnt_d = s_cnt_q;
    n_cnt_d = n_cnt_q;
    shreg_d = shreg_q;
    dout_d  = dout_q;
    done_d  = 1'b0;
    ferr_d  = 1'b0;

    case (state_q)
      UART_IDLE: begin
        if (!rx_s) begin
          state_d = UART_START;
          s_cnt_d = '0;
        end
      end

      UART_START: begin
        if (TICK) begin
          if (s_cnt_q == S_MID) begin
            // Still low at mid start bit: genuine frame, else a glitch.
            if (!rx_s) begin
              state_d = UART_DATA;
              s_cnt_d = '0;
              n_cnt_d = '0;
            end else begin
              state_d = UART_IDLE;
            end
          end else begin
            s_cnt_d = s_cnt_q + SW'(1);
          end
        end
      end

      UART_DATA: begin
        if (TICK) begin
          if (s_cnt_q == S_LAST) begin
            s_cnt_d = '0;
            shreg_d = {rx_s, shreg_q[DATA_BITS-1:1]};
            if (n_cnt_q == N_LAST) begin
              state_d = UART_STOP;
            end else begin
              n_cnt_d = n_cnt_q + NW'(1);
            end
          end else begin
            s_cnt_d = s_cnt_q + SW'(1);
          end
        end
      end

      UART_STOP: begin
        if (TICK) begin
          if (s_cnt_q == S_STOP) begin
            state_d = UART_IDLE;
            if (rx_s) begin
              dout_d = shreg_q;
              done_d = 1'b1;
            end else begin
              ferr_d = 1'b1;
            end
          end else begin
            s_cnt_d = s_cnt_q + SW'(1);
          end
        end
      end
    endcase
  end

  assign DOUT      = dout_q;
  assign RX_DONE   = done_q;
  assign FRAME_ERR = ferr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx. A behavioural model tracks the bytes that
// should be delivered, the framing errors that should be flagged and the
// value DOUT should hold; a monitor records what the DUT actually emits.
// The tick period is shortened to keep frames short in simulation.
module tb_uart_rx;

  localparam int TD  = 5;         // CLKs per TICK
  localparam int BIT = 16 * TD;   // CLKs per serial bit

  logic       CLK;
  logic       reset;
  logic       TICK;
  logic       RX;
  logic [7:0] DOUT;
  logic       RX_DONE;
  logic       FRAME_ERR;

  int checks = 0;
  int passes = 0;

  // Observations from the monitor.
  logic [7:0] obs_q[$];
  int         done_cnt = 0;
  int         ferr_cnt = 0;
  int         both_cnt = 0;
  int         cyc = 0;
  int         last_done_cyc = 0;

  // Reference model state.
  logic [7:0] exp_q[$];
  int         exp_ferr = 0;
  logic [7:0] exp_dout = 8'h00;

  uart_rx dut (
    .CLK       (CLK),
    .reset     (reset),
    .TICK      (TICK),
    .RX        (RX),
    .DOUT      (DOUT),
    .RX_DONE   (RX_DONE),
    .FRAME_ERR (FRAME_ERR)
  );

  initial CLK = 1'b0;
  always #10 CLK = ~CLK;

  // Baud generator stand-in: one-cycle TICK every TD clocks.
  initial begin
    TICK = 1'b0;
    forever begin
      repeat (TD - 1) @(negedge CLK);
      TICK = 1'b1;
      @(negedge CLK);
      TICK = 1'b0;
    end
  end

  // Output monitor, sampled on the inactive edge.
  always @(negedge CLK) begin
    cyc = cyc + 1;
    if (RX_DONE === 1'b1) begin
      obs_q.push_back(DOUT);
      done_cnt = done_cnt + 1;
      last_done_cyc = cyc;
    end
    if (FRAME_ERR === 1'b1) ferr_cnt = ferr_cnt + 1;
    if (RX_DONE === 1'b1 && FRAME_ERR === 1'b1) both_cnt = both_cnt + 1;
  end

  // Serialise one 8N1 frame. A bad frame drives the stop bit low for the
  // first 10 ticks only, so the mid-stop sample sees 0 and the line is back
  // high before any restarted frame reaches its mid-start check.
  task automatic send_frame(input logic [7:0] b, input bit good);
    RX = 1'b0;
    repeat (BIT) @(negedge CLK);
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      repeat (BIT) @(negedge CLK);
    end
    if (good) begin
      RX = 1'b1;
      repeat (BIT) @(negedge CLK);
      exp_q.push_back(b);
      exp_dout = b;
    end else begin
      RX = 1'b0;
      repeat (10 * TD) @(negedge CLK);
      RX = 1'b1;
      repeat (6 * TD) @(negedge CLK);
      exp_ferr = exp_ferr + 1;
    end
  endtask

  task automatic idle_bits(input int n);
    RX = 1'b1;
    repeat (n * BIT) @(negedge CLK);
  endtask

  task automatic test_reset;
    reset = 1'b0;
    RX    = 1'b0;
    repeat (5) @(negedge CLK);
    checks++;
    if (DOUT !== 8'h00) $display("FAIL reset_dout: got %h expected %h", DOUT, 8'h00);
    else passes++;
    checks++;
    if (RX_DONE !== 1'b0) $display("FAIL reset_rx_done: got %b expected 0", RX_DONE);
    else passes++;
    checks++;
    if (FRAME_ERR !== 1'b0) $display("FAIL reset_frame_err: got %b expected 0", FRAME_ERR);
    else passes++;
    // Line held low for a whole frame time while in reset.
    repeat (10 * BIT) @(negedge CLK);
    checks++;
    if (done_cnt + ferr_cnt !== 0)
      $display("FAIL reset_no_frame: got %0d pulses expected 0", done_cnt + ferr_cnt);
    else passes++;
    RX = 1'b1;
    repeat (2) @(negedge CLK);
    reset = 1'b1;
    idle_bits(2);
    checks++;
    if (done_cnt + ferr_cnt !== 0 || DOUT !== 8'h00)
      $display("FAIL reset_release_idle: got %0d pulses dout %h expected 0 pulses dout 00",
               done_cnt + ferr_cnt, DOUT);
    else passes++;
  endtask

  task automatic test_single;
    int d0, f0, t0, lat;
    d0 = done_cnt;
    f0 = ferr_cnt;
    t0 = cyc;
    send_frame(8'hA5, 1'b1);
    idle_bits(2);
    checks++;
    if (done_cnt - d0 !== 1) $display("FAIL single_count: got %0d expected 1", done_cnt - d0);
    else passes++;
    checks++;
    if (DOUT !== exp_dout) $display("FAIL single_dout: got %h expected %h", DOUT, exp_dout);
    else passes++;
    checks++;
    if (ferr_cnt !== f0) $display("FAIL single_ferr: got %0d expected 0", ferr_cnt - f0);
    else passes++;
    // Nominal mid-stop sample is 9.5 bits after the start edge.
    lat = last_done_cyc - t0;
    checks++;
    if (lat < 19 * BIT / 2 - TD || lat > 19 * BIT / 2 + 2 * TD)
      $display("FAIL single_latency: got %0d cycles expected %0d..%0d",
               lat, 19 * BIT / 2 - TD, 19 * BIT / 2 + 2 * TD);
    else passes++;
  endtask

  task automatic test_back_to_back;
    int n0, e0, f0;
    logic [7:0] got;
    n0 = obs_q.size();
    e0 = exp_q.size();
    f0 = ferr_cnt;
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'h55, 1'b1);
    idle_bits(2);
    checks++;
    if (obs_q.size() - n0 !== 3) $display("FAIL b2b_count: got %0d expected 3", obs_q.size() - n0);
    else passes++;
    for (int i = 0; i < 3; i++) begin
      got = (n0 + i < obs_q.size()) ? obs_q[n0 + i] : 8'hxx;
      checks++;
      if (got !== exp_q[e0 + i]) $display("FAIL b2b_byte%0d: got %h expected %h", i, got, exp_q[e0 + i]);
      else passes++;
    end
    checks++;
    if (ferr_cnt !== f0) $display("FAIL b2b_ferr: got %0d expected 0", ferr_cnt - f0);
    else passes++;
  endtask

  task automatic test_glitch;
    int d0, f0;
    d0 = done_cnt;
    f0 = ferr_cnt;
    RX = 1'b0;
    repeat (4 * TD) @(negedge CLK);
    idle_bits(2);
    checks++;
    if (done_cnt !== d0 || ferr_cnt !== f0)
      $display("FAIL glitch_no_pulse: got done %0d ferr %0d expected 0 0", done_cnt - d0, ferr_cnt - f0);
    else passes++;
    send_frame(8'h3C, 1'b1);
    idle_bits(1);
    checks++;
    if (done_cnt - d0 !== 1 || DOUT !== exp_dout)
      $display("FAIL glitch_next_byte: got %0d pulses dout %h expected 1 pulse dout %h",
               done_cnt - d0, DOUT, exp_dout);
    else passes++;
  endtask

  task automatic test_frame_err;
    int d0, f0;
    d0 = done_cnt;
    f0 = ferr_cnt;
    send_frame(8'h81, 1'b0);
    idle_bits(2);
    checks++;
    if (ferr_cnt - f0 !== 1) $display("FAIL ferr_count: got %0d expected 1", ferr_cnt - f0);
    else passes++;
    checks++;
    if (done_cnt !== d0) $display("FAIL ferr_no_done: got %0d expected 0", done_cnt - d0);
    else passes++;
    checks++;
    if (DOUT !== exp_dout) $display("FAIL ferr_dout_held: got %h expected %h", DOUT, exp_dout);
    else passes++;
  endtask

  task automatic test_reset_midframe;
    int d0, f0;
    logic [7:0] b;
    b  = 8'hC3;
    d0 = done_cnt;
    f0 = ferr_cnt;
    RX = 1'b0;
    repeat (BIT) @(negedge CLK);
    for (int i = 0; i < 4; i++) begin
      RX = b[i];
      repeat (BIT) @(negedge CLK);
    end
    reset = 1'b0;
    RX    = 1'b1;
    exp_dout = 8'h00;
    repeat (5) @(negedge CLK);
    checks++;
    if (DOUT !== exp_dout) $display("FAIL midreset_dout: got %h expected %h", DOUT, exp_dout);
    else passes++;
    reset = 1'b1;
    idle_bits(2);
    checks++;
    if (done_cnt !== d0 || ferr_cnt !== f0)
      $display("FAIL midreset_no_pulse: got done %0d ferr %0d expected 0 0", done_cnt - d0, ferr_cnt - f0);
    else passes++;
    send_frame(8'h7E, 1'b1);
    idle_bits(1);
    checks++;
    if (done_cnt - d0 !== 1) $display("FAIL midreset_count: got %0d expected 1", done_cnt - d0);
    else passes++;
    checks++;
    if (DOUT !== exp_dout) $display("FAIL midreset_dout_next: got %h expected %h", DOUT, exp_dout);
    else passes++;
  endtask

  task automatic test_random;
    int n0, e0, f0, ef0, gap;
    bit good, prev_good;
    logic [7:0] b, got;
    n0 = obs_q.size();
    e0 = exp_q.size();
    f0 = ferr_cnt;
    ef0 = exp_ferr;
    prev_good = 1'b1;
    for (int k = 0; k < 20; k++) begin
      b    = 8'($urandom);
      good = ($urandom_range(0, 4) != 0);
      gap  = $urandom_range(0, 2);
      if (!prev_good && gap == 0) gap = 1;
      if (gap > 0) idle_bits(gap);
      send_frame(b, good);
      prev_good = good;
    end
    idle_bits(2);
    checks++;
    if (obs_q.size() - n0 !== exp_q.size() - e0)
      $display("FAIL rand_count: got %0d expected %0d", obs_q.size() - n0, exp_q.size() - e0);
    else passes++;
    for (int i = 0; i < exp_q.size() - e0; i++) begin
      got = (n0 + i < obs_q.size()) ? obs_q[n0 + i] : 8'hxx;
      checks++;
      if (got !== exp_q[e0 + i]) $display("FAIL rand_byte%0d: got %h expected %h", i, got, exp_q[e0 + i]);
      else passes++;
    end
    checks++;
    if (ferr_cnt - f0 !== exp_ferr - ef0)
      $display("FAIL rand_ferr: got %0d expected %0d", ferr_cnt - f0, exp_ferr - ef0);
    else passes++;
    checks++;
    if (DOUT !== exp_dout) $display("FAIL rand_dout: got %h expected %h", DOUT, exp_dout);
    else passes++;
  endtask

  task automatic test_exclusive;
    checks++;
    if (both_cnt !== 0) $display("FAIL done_ferr_exclusive: got %0d overlaps expected 0", both_cnt);
    else passes++;
  endtask

  initial begin
    reset = 1'b0;
    RX    = 1'b1;
    test_reset;
    test_single;
    test_back_to_back;
    test_glitch;
    test_frame_err;
    test_reset_midframe;
    test_random;
    test_exclusive;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
